gemm_drain: RTL
===============

GEMM_DRAIN -- requirements
Module: gemm_drain

Interface
REQ-001 Parameter DIM, default 16: square array dimension, i.e. rows and columns of the result matrix.
REQ-002 Parameter OUT_BITS, default 16: width of each raw MAC result element.
REQ-003 Parameter OUT_W, default 8: output element width when GEMM_DRAIN_SAT_EN is defined.
REQ-004 Parameter SHIFT, default 0: right-shift applied before saturation when GEMM_DRAIN_SAT_EN is defined.
REQ-005 Port list SHALL be:
- clk  input  1  sole clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- res_in  input  DIM x DIM x OUT_BITS  result matrix from the MAC array, indexed [row][col].
- res_valid  input  1  single-cycle pulse marking res_in as complete (array finished).
- busy  output  1  high while a captured matrix is still being drained.
- row_data  output  DIM x EW  current row, where EW = OUT_W if GEMM_DRAIN_SAT_EN is defined, else OUT_BITS.
- row_idx  output  $clog2(DIM)  index of the row on row_data.
- row_valid  output  1  row_data is valid.
- row_ready  input  1  downstream accepts the row.
- row_last  output  1  row_idx == DIM-1 and row_valid is high.
- overrun  output  1  sticky flag: a res_valid pulse was dropped.

Function
REQ-006 States SHALL be IDLE and DRAIN.
REQ-007 In IDLE, res_valid=1 SHALL capture all of res_in into an internal DIM x DIM buffer, set row counter=0 and enter DRAIN on the next edge.
REQ-008 In DRAIN, row_valid SHALL be 1, row_data SHALL equal buf[row counter], and row_idx SHALL equal the row counter.
REQ-009 A beat completes on row_valid & row_ready; row counter SHALL then increment by 1.
REQ-010 If row_valid=1 and row_ready=0, row_data and row_idx SHALL hold stable.
REQ-011 A beat completing with row counter == DIM-1 SHALL return the FSM to IDLE with row counter=0.
REQ-012 If res_valid=1 in the same cycle that the last beat completes, the block SHALL capture the new matrix and stay in DRAIN at row 0, so back-to-back drains have no bubble.
REQ-013 Any other res_valid=1 while in DRAIN SHALL be ignored: the buffer is unchanged and overrun is set to 1.
REQ-014 overrun SHALL stay set until reset.
REQ-015 busy SHALL be 1 exactly when state==DRAIN.
REQ-016 Minimum latency SHALL be 1 cycle from the res_valid edge to row_valid=1.
REQ-017 Draining a matrix SHALL take DIM beats; with row_ready held high, it SHALL take exactly DIM cycles.
REQ-018 The buffer SHALL load only on an accepted capture; it SHALL NOT be otherwise written.

Reset
REQ-019 reset_n=0 SHALL asynchronously force: state=IDLE, row counter=0, row_valid=0, busy=0, overrun=0, row_idx=0, row_data=0.
REQ-020 A reset during DRAIN SHALL abandon the matrix; no partial row SHALL be re-presented after reset release.
REQ-021 Buffer contents need not be reset.

Configuration
REQ-022 Macro GEMM_DRAIN_SAT_EN defined: each element SHALL be min(res >> SHIFT, 2^OUT_W - 1) as unsigned, applied combinationally on the output path to the raw buffer.
REQ-023 Macro GEMM_DRAIN_SAT_EN undefined: each element SHALL be passed raw at OUT_BITS width, and OUT_W and SHIFT SHALL be unused.

Structure
REQ-024 Package gemm_pkg SHALL hold the drain state enum typedef and the default DIM/OUT_BITS constants shared with the multiplier array.
REQ-025 Saturation SHALL live in one sub-module, gemm_sat (one element, parameterised by OUT_BITS/OUT_W/SHIFT), instantiated DIM times under GEMM_DRAIN_SAT_EN.

Verification
REQ-026 DIM=4, res_in[r][c]=4r+c, pulse res_valid, row_ready=1 -> rows 0..3 on 4 consecutive cycles; row 2 = {8,9,10,11}; row_last only on row 3; busy low on the following cycle.
REQ-027 row_ready toggling 1,0,0,1 during a drain -> row_data/row_idx constant across the stalled cycles, and no row is skipped or duplicated.
REQ-028 Second res_valid pulse while on row 1 -> overrun=1, second matrix dropped, first matrix drains intact; res_valid coincident with the row-3 handshake -> new row 0 next cycle, overrun unchanged.
REQ-029 reset_n asserted mid-drain at row 2 -> row_valid=0, busy=0, overrun=0 immediately; next res_valid drain starts at row 0.
REQ-030 GEMM_DRAIN_SAT_EN, OUT_BITS=16, OUT_W=8, SHIFT=2: element 1000 -> 250; element 1024 -> 255; element 3 -> 0.

Source files
------------

// File: rtl/gemm_pkg.sv
// Shared GEMM constants and drain FSM state type.
// Used by gemm_drain and the multiplier array.
package gemm_pkg;
  localparam int GEMM_DIM      = 16;
  localparam int GEMM_OUT_BITS = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;
endpackage

// File: rtl/gemm_sat.sv
// One-element output conditioner: logical right shift,
// then unsigned clamp to OUT_W bits.
module gemm_sat #(
  parameter int OUT_BITS = 16,
  parameter int OUT_W    = 8,
  parameter int SHIFT    = 0
) (
  input  logic [OUT_BITS-1:0] din,
  output logic [OUT_W-1:0]    dout
);
  localparam logic [OUT_BITS-1:0] MAXV =
    OUT_BITS'((64'd1 << OUT_W) - 64'd1);

  logic [OUT_BITS-1:0] shd;

  always_comb begin
    shd  = din >> SHIFT;
    dout = (shd > MAXV) ? OUT_W'(MAXV)
                        : OUT_W'(shd);
  end
endmodule

// File: rtl/gemm_drain.sv
// Captures a finished MAC result matrix and streams it out row by row.
// Optional output saturation: define GEMM_DRAIN_SAT_EN.
module gemm_drain
  import gemm_pkg::*;
#(
  parameter int DIM      = GEMM_DIM,
  parameter int OUT_BITS = GEMM_OUT_BITS,
  parameter int OUT_W    = 8,
  parameter int SHIFT    = 0,
`ifdef GEMM_DRAIN_SAT_EN
  localparam int EW      = OUT_W,
`else
  localparam int EW      = OUT_BITS,
`endif
  localparam int IW      = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [DIM-1:0][DIM-1:0][OUT_BITS-1:0] res_in,
  input  logic                               res_valid,
  output logic                               busy,
  output logic [DIM-1:0][EW-1:0]             row_data,
  output logic [IW-1:0]                      row_idx,
  output logic                               row_valid,
  input  logic                               row_ready,
  output logic                               row_last,
  output logic                               overrun
);
  drain_state_e  state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          ovr_q, ovr_d;
  logic          load, fire, last;

  logic [DIM-1:0][DIM-1:0][OUT_BITS-1:0] mat_q;
  logic [DIM-1:0][OUT_BITS-1:0]          raw_row;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    load    = 1'b0;
    fire    = (state_q == ST_DRAIN) && row_ready;
    last    = (cnt_q == IW'(DIM - 1));
    unique case (state_q)
      ST_IDLE: begin
        if (res_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fire) begin
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
        // only the final handshake frees the buffer for a new matrix
        if (res_valid) begin
          if (fire && last) begin
            load    = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) mat_q <= res_in;
  end

  assign busy      = (state_q == ST_DRAIN);
  assign row_valid = busy;
  assign row_idx   = cnt_q;
  assign row_last  = busy && last;
  assign overrun   = ovr_q;
  assign raw_row   = busy ? mat_q[cnt_q] : '0;

`ifdef GEMM_DRAIN_SAT_EN
  for (genvar gi = 0; gi < DIM; gi++) begin : g_sat
    gemm_sat #(
      .OUT_BITS(OUT_BITS),
      .OUT_W   (OUT_W),
      .SHIFT   (SHIFT)
    ) u_sat (
      .din (raw_row[gi]),
      .dout(row_data[gi])
    );
  end
`else
  assign row_data = raw_row;
`endif
endmodule
